// File: rtl/espi_master_if.sv
// Local-controller side of the eSPI master: start request, command/write bytes in,
// read byte and completion pulse out.
interface espi_master_if;
  logic       start_transaction;
  logic [7:0] command;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       transaction_done;

  modport master (
    input  start_transaction, command, write_data,
    output read_data, transaction_done
  );

  modport slave (
    output start_transaction, command, write_data,
    input  read_data, transaction_done
  );
endinterface

// File: rtl/espi_master.sv
// Single-lane eSPI-style master: CS setup, 8-bit command, 8-bit write, 2-period turnaround,
// 8-bit read, CS hold; SPI mode 0 with sclk half-period of CLK_DIV clk cycles.
module espi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          reset,
  espi_master_if.master ctrl,
  output logic          sclk,
  output logic          cs_n,
  inout  wire           io0
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, WDATA, TAR, RDATA, CS_HOLD, DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [15:0]   tx_sr;
  logic [7:0]    rx_sr;
  logic          io_oe;
  logic          start_s;
  logic          start_q;
  logic          half_end;
  logic          start_rise;

  assign half_end   = (div_cnt == DIV_LAST);
  assign start_rise = start_s & ~start_q;
  // The bit on the line is always the MSB of the transmit shifter.
  assign io0        = io_oe ? tx_sr[15] : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      cs_n                  <= 1'b1;
      sclk                  <= 1'b0;
      io_oe                 <= 1'b0;
      div_cnt               <= '0;
      bit_cnt               <= '0;
      start_s               <= 1'b0;
      start_q               <= 1'b0;
      ctrl.transaction_done <= 1'b0;
      ctrl.read_data        <= 8'h00;
    end else begin
      start_s               <= ctrl.start_transaction;
      start_q               <= start_s;
      ctrl.transaction_done <= 1'b0;
      div_cnt               <= half_end ? '0 : div_cnt + 1'b1;

      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (start_rise) begin
            tx_sr   <= {ctrl.command, ctrl.write_data};
            cs_n    <= 1'b0;
            io_oe   <= 1'b1;
            bit_cnt <= '0;
            state   <= CS_SETUP;
          end
        end

        CS_SETUP: if (half_end) state <= CMD;

        CMD, WDATA, TAR, RDATA: if (half_end) begin
          sclk <= ~sclk;
          if (!sclk) begin
            if (state == RDATA) rx_sr <= {rx_sr[6:0], io0};
          end else begin
            // Falling edge: advance to the next bit, or to the next phase on the last one.
            tx_sr   <= {tx_sr[14:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == ((state == TAR) ? 3'd1 : 3'd7)) begin
              bit_cnt <= '0;
              case (state)
                CMD:     state <= WDATA;
                WDATA: begin
                  state <= TAR;
                  io_oe <= 1'b0;
                end
                TAR:     state <= RDATA;
                default: state <= CS_HOLD;
              endcase
            end
          end
        end

        CS_HOLD: if (half_end) begin
          cs_n  <= 1'b1;
          state <= DONE;
        end

        default: begin
          ctrl.read_data        <= rx_sr;
          ctrl.transaction_done <= 1'b1;
          state                 <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_espi_master.sv
// Bench for espi_master: two instances (CLK_DIV=2 and CLK_DIV=1), each with a behavioural
// companion slave, checked against timing and response rules computed in plain arithmetic.
module tb_espi_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic       start_r [2];
  logic [7:0] cmd_r   [2];
  logic [7:0] wd_r    [2];
  logic [1:0] sclk_v, csn_v, io_v;
  wire        io0_a, io0_b;

  espi_master_if bus_a ();
  espi_master_if bus_b ();

  assign bus_a.start_transaction = start_r[0];
  assign bus_a.command           = cmd_r[0];
  assign bus_a.write_data        = wd_r[0];
  assign bus_b.start_transaction = start_r[1];
  assign bus_b.command           = cmd_r[1];
  assign bus_b.write_data        = wd_r[1];
  assign io_v = {io0_b, io0_a};

  espi_master #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .ctrl(bus_a.master),
    .sclk(sclk_v[0]), .cs_n(csn_v[0]), .io0(io0_a)
  );

  espi_master #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .ctrl(bus_b.master),
    .sclk(sclk_v[1]), .cs_n(csn_v[1]), .io0(io0_b)
  );

  pulldown (io0_a);
  pulldown (io0_b);

  function automatic logic [7:0] slave_resp(input logic [7:0] c, input logic [7:0] d);
    case (c)
      8'h01:   return d;
      8'h02:   return ~d;
      default: return 8'h00;
    endcase
  endfunction

  // Companion slave A: samples on sclk rise, drives on fall, releases while cs_n is high.
  int         s_cnt_a = 0, pulses_a = 0, stray_a = 0;
  logic [15:0] s_in_a = '0;
  logic        s_oe_a = 1'b0, s_d_a = 1'b0;
  logic [7:0]  resp_a;
  assign resp_a = slave_resp(s_in_a[15:8], s_in_a[7:0]);
  assign io0_a  = s_oe_a ? s_d_a : 1'bz;
  always @(posedge sclk_v[0]) begin
    pulses_a <= pulses_a + 1;
    if (csn_v[0]) stray_a <= stray_a + 1;
  end
  always @(posedge sclk_v[0] or posedge csn_v[0]) begin
    if (csn_v[0]) s_cnt_a <= 0;
    else begin
      s_cnt_a <= s_cnt_a + 1;
      if (s_cnt_a < 16) s_in_a <= {s_in_a[14:0], io_v[0]};
    end
  end
  always @(negedge sclk_v[0] or posedge csn_v[0]) begin
    if (csn_v[0]) s_oe_a <= 1'b0;
    else if (s_cnt_a >= 18 && s_cnt_a <= 25) begin
      s_oe_a <= 1'b1;
      s_d_a  <= resp_a[3'(25 - s_cnt_a)];
    end else s_oe_a <= 1'b0;
  end

  // Companion slave B, same contract.
  int         s_cnt_b = 0, pulses_b = 0, stray_b = 0;
  logic [15:0] s_in_b = '0;
  logic        s_oe_b = 1'b0, s_d_b = 1'b0;
  logic [7:0]  resp_b;
  assign resp_b = slave_resp(s_in_b[15:8], s_in_b[7:0]);
  assign io0_b  = s_oe_b ? s_d_b : 1'bz;
  always @(posedge sclk_v[1]) begin
    pulses_b <= pulses_b + 1;
    if (csn_v[1]) stray_b <= stray_b + 1;
  end
  always @(posedge sclk_v[1] or posedge csn_v[1]) begin
    if (csn_v[1]) s_cnt_b <= 0;
    else begin
      s_cnt_b <= s_cnt_b + 1;
      if (s_cnt_b < 16) s_in_b <= {s_in_b[14:0], io_v[1]};
    end
  end
  always @(negedge sclk_v[1] or posedge csn_v[1]) begin
    if (csn_v[1]) s_oe_b <= 1'b0;
    else if (s_cnt_b >= 18 && s_cnt_b <= 25) begin
      s_oe_b <= 1'b1;
      s_d_b  <= resp_b[3'(25 - s_cnt_b)];
    end else s_oe_b <= 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input bit w, input string tag);
    chk({tag, "_cs_n"}, csn_v[w], 1'b1);
    chk({tag, "_sclk"}, sclk_v[w], 1'b0);
    chk({tag, "_io0"}, io_v[w], 1'b0);
    chk({tag, "_done"}, w ? bus_b.transaction_done : bus_a.transaction_done, 1'b0);
    chk({tag, "_rdata"}, w ? bus_b.read_data : bus_a.read_data, 8'h00);
  endtask

  // One transaction; n is the clk edge where the rising start is first sampled.
  task automatic run_txn(input bit w, input logic [7:0] c, input logic [7:0] d,
                         input bit busy, input bit stop_at_done);
    int h, n, m, j, falls, fall_m, dones, done_m, hi, lo, p0, s0;
    logic prev_cs, dn;
    logic [7:0] ex, rd_at;
    h = w ? 1 : 2;
    ex = slave_resp(c, d);
    @(posedge clk); #1;
    start_r[w] = 1'b1; cmd_r[w] = c; wd_r[w] = d;
    n = cyc + 1;
    p0 = w ? pulses_b : pulses_a;
    s0 = w ? stray_b : stray_a;
    prev_cs = 1'b1; falls = 0; fall_m = -1; dones = 0; done_m = -1; hi = 0; lo = 0; rd_at = 8'h00;
    for (int k = 0; k < 54 * h + 20; k++) begin
      @(posedge clk); #1;
      m = cyc - n;
      if (m == 3) begin
        start_r[w] = 1'b0; cmd_r[w] = ~c; wd_r[w] = ~d;
      end
      if (busy && m == 1 + 2 * h + 24 * h) start_r[w] = 1'b1;
      if (busy && m == 3 + 2 * h + 24 * h) start_r[w] = 1'b0;
      if (!csn_v[w] && prev_cs) begin
        falls++;
        if (falls == 1) fall_m = m;
      end
      prev_cs = csn_v[w];
      if (!csn_v[w]) lo++;
      if (sclk_v[w]) hi++;
      dn = w ? bus_b.transaction_done : bus_a.transaction_done;
      if (dn) begin
        dones++; done_m = m;
        rd_at = w ? bus_b.read_data : bus_a.read_data;
      end
      if (m == 1 + 34 * h) chk("tar_released", io_v[w], 1'b0);
      if (m >= 1 + 38 * h && ((m - 1 - 2 * h) % (2 * h)) == 0) begin
        j = (m - 1 - 2 * h) / (2 * h) - 18;
        if (j >= 0 && j < 8) chk("rdata_bit", io_v[w], ex[3'(7 - j)]);
      end
      if (stop_at_done && dones > 0) break;
    end
    chk("cs_fall_count", falls, 1);
    chk("cs_fall_cycle", fall_m, 1);
    chk("done_count", dones, 1);
    chk("done_cycle", done_m, 2 + 54 * h);
    chk("read_at_done", rd_at, ex);
    chk("read_hold", w ? bus_b.read_data : bus_a.read_data, ex);
    chk("sclk_pulses", (w ? pulses_b : pulses_a) - p0, 26);
    chk("sclk_cs_high", (w ? stray_b : stray_a) - s0, 0);
    chk("sclk_high_cycles", hi, 26 * h);
    chk("cs_low_cycles", lo, 54 * h);
    chk("slave_rx", w ? s_in_b : s_in_a, {c, d});
  endtask

  task automatic reset_test();
    int n, m;
    @(posedge clk); #1;
    start_r[0] = 1'b1; cmd_r[0] = 8'h01; wd_r[0] = 8'hFF;
    n = cyc + 1;
    m = 0;
    for (int k = 0; k < 200 && m < 45; k++) begin
      @(posedge clk); #1;
      m = cyc - n;
      if (m == 3) start_r[0] = 1'b0;
    end
    chk("rst_pre_wdata_drive", io_v[0], 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle(1'b0, "rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_restart", csn_v[0], 1'b1);
  endtask

  initial begin
    logic [7:0] c, d;
    int sel;
    for (int i = 0; i < 2; i++) begin
      start_r[i] = 1'b0; cmd_r[i] = 8'h00; wd_r[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle(1'b0, "rst_a");
    check_idle(1'b1, "rst_b");
    reset = 1'b0;

    run_txn(1'b0, 8'h01, 8'hAA, 1'b0, 1'b0);
    run_txn(1'b0, 8'h02, 8'h3C, 1'b0, 1'b0);
    reset_test();
    run_txn(1'b0, 8'h7F, 8'($urandom), 1'b0, 1'b0);
    run_txn(1'b0, 8'h01, 8'($urandom), 1'b1, 1'b0);

    // CLK_DIV=1, restarting as soon as done is seen.
    run_txn(1'b1, 8'h01, 8'h55, 1'b0, 1'b1);
    run_txn(1'b1, 8'h01, 8'hFF, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      sel = $urandom_range(0, 2);
      c = (sel == 0) ? 8'h01 : (sel == 1) ? 8'h02 : 8'($urandom);
      d = 8'($urandom);
      run_txn(1'(i % 2), c, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
